// File: rtl/miter_chk_pkg.sv
// Shared types and default sizing for the miter checker.
// Optional stop-on-first-mismatch behaviour is selected by MITER_CHK_STOP_ON_FAIL_EN.
package miter_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_CW     = 8;
  localparam int unsigned DEF_WINDOW = 32;
  // Cycle index is sized for the largest legal window, independent of CW.
  localparam int unsigned IDX_W      = 8;

endpackage

// File: rtl/miter_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; it holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/miter_checker.sv
// Observes a miter output over WINDOW enabled cycles and reports pass/fail statistics.
// Define MITER_CHK_STOP_ON_FAIL_EN to end a run on its first sampled mismatch.
module miter_checker
  import miter_chk_pkg::*;
#(
  parameter int unsigned WINDOW = DEF_WINDOW,
  parameter int unsigned CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          enable,
  input  logic          m_out,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic          pass,
  output logic [CW-1:0] first_fail_cycle,
  output logic [CW-1:0] mismatch_count
);

  state_e           state_q;
  logic             busy_q, done_q, fail_q, pass_q;
  logic [CW-1:0]    ffc_q;
  logic [IDX_W-1:0] idx_q;

  logic sample_c, last_c, stop_c, clr_c;

  assign sample_c = (state_q == RUN) && enable;
  assign last_c   = (idx_q == IDX_W'(WINDOW - 1));
  assign clr_c    = (state_q != RUN) && start;

`ifdef MITER_CHK_STOP_ON_FAIL_EN
  assign stop_c = m_out;
`else
  assign stop_c = 1'b0;
`endif

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      pass_q  <= 1'b0;
      ffc_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            ffc_q   <= '0;
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (enable) begin
            idx_q <= idx_q + IDX_W'(1);
            if (m_out && !fail_q) begin
              fail_q <= 1'b1;
              ffc_q  <= CW'(idx_q);
            end
            if (last_c || stop_c) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= !(fail_q || m_out);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(CW)) u_mismatch_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_c),
    .inc   (sample_c && m_out),
    .count (mismatch_count)
  );

  assign busy             = busy_q;
  assign done             = done_q;
  assign fail             = fail_q;
  assign pass             = pass_q;
  assign first_fail_cycle = ffc_q;

endmodule

// File: tb/tb_miter_checker.sv
// Directed self-checking bench: a default checker plus a narrow CW=2, WINDOW=8 instance.
module tb_miter_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic enable = 1'b0;
  logic m_out = 1'b0;

  logic       d1_busy, d1_done, d1_fail, d1_pass;
  logic [7:0] d1_ffc, d1_cnt;
  logic       d2_busy, d2_done, d2_fail, d2_pass;
  logic [1:0] d2_ffc, d2_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  miter_checker #(.WINDOW(32), .CW(8)) dut1 (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .m_out(m_out),
    .busy(d1_busy), .done(d1_done), .fail(d1_fail), .pass(d1_pass),
    .first_fail_cycle(d1_ffc), .mismatch_count(d1_cnt)
  );

  miter_checker #(.WINDOW(8), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .m_out(m_out),
    .busy(d2_busy), .done(d2_done), .fail(d2_fail), .pass(d2_pass),
    .first_fail_cycle(d2_ffc), .mismatch_count(d2_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; enable = 1'b0; m_out = 1'b0;
    tick(); tick();
    n_checks++;
    if ({d1_busy, d1_done, d1_fail, d1_pass} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {d1_busy, d1_done, d1_fail, d1_pass});
    end
    n_checks++;
    if ({d1_ffc, d1_cnt} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_regs got %h exp 0000", {d1_ffc, d1_cnt});
    end
    n_checks++;
    if ({d2_busy, d2_done, d2_fail, d2_pass, d2_ffc, d2_cnt} !== 8'h00) begin
      n_fail++; $display("FAIL reset_dut2 got %h exp 00", {d2_busy, d2_done, d2_fail, d2_pass, d2_ffc, d2_cnt});
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (d1_busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_start got busy=%b exp 0", d1_busy);
    end
  endtask

  task automatic test_clean_run();
    start = 1'b1; enable = 1'b1; m_out = 1'b0;
    tick();
    start = 1'b0;
    n_checks++;
    if ({d1_busy, d1_done} !== 2'b10) begin
      n_fail++; $display("FAIL clean_enter got busy,done=%b exp 10", {d1_busy, d1_done});
    end
    repeat (31) tick();
    n_checks++;
    if ({d1_busy, d1_done} !== 2'b10) begin
      n_fail++; $display("FAIL clean_31 got busy,done=%b exp 10", {d1_busy, d1_done});
    end
    tick();
    n_checks++;
    if ({d1_busy, d1_done, d1_pass, d1_fail} !== 4'b0110 || d1_cnt !== 8'd0) begin
      n_fail++; $display("FAIL clean_done got b,d,p,f=%b cnt=%0d exp 0110 cnt=0", {d1_busy, d1_done, d1_pass, d1_fail}, d1_cnt);
    end
    m_out = 1'b1;
    tick(); tick();
    n_checks++;
    if ({d1_done, d1_pass} !== 2'b11 || d1_cnt !== 8'd0) begin
      n_fail++; $display("FAIL done_ignores_mout got d,p=%b cnt=%0d exp 11 cnt=0", {d1_done, d1_pass}, d1_cnt);
    end
    m_out = 1'b0;
  endtask

  task automatic test_two_fails();
    start = 1'b1; enable = 1'b1; m_out = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_out = (i == 5 || i == 9);
      if (i == 10) start = 1'b1;
      tick();
      start = 1'b0;
      if (i == 4) begin
        n_checks++;
        if (d1_fail !== 1'b0) begin
          n_fail++; $display("FAIL two_pre got fail=%b exp 0", d1_fail);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (d1_fail !== 1'b1 || d1_ffc !== 8'd5 || d1_cnt !== 8'd1) begin
          n_fail++; $display("FAIL two_first got fail=%b ffc=%0d cnt=%0d exp 1 5 1", d1_fail, d1_ffc, d1_cnt);
        end
      end
      if (i == 10) begin
        n_checks++;
        if (d1_busy !== 1'b1 || d1_cnt !== 8'd2 || d1_ffc !== 8'd5) begin
          n_fail++; $display("FAIL start_in_run got busy=%b cnt=%0d ffc=%0d exp 1 2 5", d1_busy, d1_cnt, d1_ffc);
        end
      end
    end
    m_out = 1'b0;
    n_checks++;
    if ({d1_done, d1_fail, d1_pass} !== 3'b110 || d1_ffc !== 8'd5 || d1_cnt !== 8'd2) begin
      n_fail++; $display("FAIL two_done got d,f,p=%b ffc=%0d cnt=%0d exp 110 5 2", {d1_done, d1_fail, d1_pass}, d1_ffc, d1_cnt);
    end
  endtask

  task automatic test_enable_gap();
    start = 1'b1; enable = 1'b1; m_out = 1'b0;
    tick();
    start = 1'b0;
    repeat (10) tick();
    enable = 1'b0; m_out = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (d1_busy !== 1'b1 || d1_fail !== 1'b0 || d1_cnt !== 8'd0) begin
      n_fail++; $display("FAIL gap_frozen got busy=%b fail=%b cnt=%0d exp 1 0 0", d1_busy, d1_fail, d1_cnt);
    end
    enable = 1'b1; m_out = 1'b0;
    repeat (21) tick();
    n_checks++;
    if (d1_done !== 1'b0) begin
      n_fail++; $display("FAIL gap_early got done=%b exp 0", d1_done);
    end
    tick();
    n_checks++;
    if ({d1_done, d1_pass, d1_fail} !== 3'b110 || d1_cnt !== 8'd0) begin
      n_fail++; $display("FAIL gap_done got d,p,f=%b cnt=%0d exp 110 0", {d1_done, d1_pass, d1_fail}, d1_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; enable = 1'b1; m_out = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      m_out = (i == 2);
      tick();
    end
    m_out = 1'b1;
    n_checks++;
    if (d1_fail !== 1'b1 || d1_ffc !== 8'd2) begin
      n_fail++; $display("FAIL mid_pre got fail=%b ffc=%0d exp 1 2", d1_fail, d1_ffc);
    end
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; m_out = 1'b0;
    n_checks++;
    if ({d1_busy, d1_done, d1_fail, d1_pass} !== 4'b0000 || d1_ffc !== 8'd0 || d1_cnt !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset got b,d,f,p=%b ffc=%0d cnt=%0d exp 0000 0 0", {d1_busy, d1_done, d1_fail, d1_pass}, d1_ffc, d1_cnt);
    end
    tick();
    n_checks++;
    if (d1_busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_stay_idle got busy=%b exp 0", d1_busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    n_checks++;
    if ({d1_done, d1_pass, d1_fail} !== 3'b110 || d1_ffc !== 8'd0 || d1_cnt !== 8'd0) begin
      n_fail++; $display("FAIL mid_rerun got d,p,f=%b ffc=%0d cnt=%0d exp 110 0 0", {d1_done, d1_pass, d1_fail}, d1_ffc, d1_cnt);
    end
  endtask

  task automatic test_saturate();
    start = 1'b1; enable = 1'b1; m_out = 1'b0;
    tick();
    start = 1'b0; m_out = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (d2_cnt !== 2'd3 || d2_busy !== 1'b1) begin
      n_fail++; $display("FAIL sat_reach got cnt=%0d busy=%b exp 3 1", d2_cnt, d2_busy);
    end
    repeat (5) tick();
    n_checks++;
    if (d2_cnt !== 2'd3 || {d2_done, d2_fail, d2_pass} !== 3'b110 || d2_ffc !== 2'd0) begin
      n_fail++; $display("FAIL sat_hold got cnt=%0d d,f,p=%b ffc=%0d exp 3 110 0", d2_cnt, {d2_done, d2_fail, d2_pass}, d2_ffc);
    end
    n_checks++;
    if (d1_cnt !== 8'd8 || d1_busy !== 1'b1) begin
      n_fail++; $display("FAIL wide_count got cnt=%0d busy=%b exp 8 1", d1_cnt, d1_busy);
    end
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; m_out = 1'b0;
    n_checks++;
    if ({d2_busy, d2_done, d2_fail, d2_pass, d2_cnt} !== 6'd0 || {d1_busy, d1_cnt} !== 9'd0) begin
      n_fail++; $display("FAIL start_reset got d2=%b d1 busy=%b cnt=%0d exp 0", {d2_busy, d2_done, d2_fail, d2_pass, d2_cnt}, d1_busy, d1_cnt);
    end
  endtask

  task automatic test_stop_on_fail();
    start = 1'b1; enable = 1'b1; m_out = 1'b0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    m_out = 1'b1;
    tick();
    m_out = 1'b0;
    n_checks++;
    if ({d1_done, d1_fail, d1_busy, d1_pass} !== 4'b1100 || d1_ffc !== 8'd3 || d1_cnt !== 8'd1) begin
      n_fail++; $display("FAIL stop_on_fail got d,f,b,p=%b ffc=%0d cnt=%0d exp 1100 3 1", {d1_done, d1_fail, d1_busy, d1_pass}, d1_ffc, d1_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_enable_gap();
`ifdef MITER_CHK_STOP_ON_FAIL_EN
    test_stop_on_fail();
`else
    test_two_fails();
    test_reset_mid_run();
    test_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miter_checker.md
MITER_CHECKER -- requirements
Module: miter_checker

Interface
REQ-001 Parameter WINDOW, default 32: number of enabled cycles observed per run (legal 2..255).
REQ-002 Parameter CW, default 8: width of the cycle index and mismatch count.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 start  input  1  single-cycle pulse that opens an observation run.
REQ-006 enable  input  1  qualifier shared with the miter under test; high = cycle counts and m_out is sampled.
REQ-007 m_out  input  1  miter output; 1 = implementations disagree this cycle.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  high while in DONE.
REQ-010 fail  output  1  sticky; high once any sampled mismatch occurs in the current run.
REQ-011 pass  output  1  high only in DONE with fail low.
REQ-012 first_fail_cycle  output  CW  enabled-cycle index (0-based) of the first sampled mismatch.
REQ-013 mismatch_count  output  CW  number of sampled mismatches, saturating at 2^CW-1.

Function
REQ-014 FSM states: IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE: start=1 -> RUN next cycle, clearing cycle index, fail, first_fail_cycle and mismatch_count.
REQ-016 RUN: on a cycle with enable=1, sample m_out and increment cycle index by 1.
REQ-017 RUN, enable=0: cycle index, counters and m_out sampling frozen; state unchanged.
REQ-018 Sampled m_out=1 with fail low: fail=1 and first_fail_cycle=current index on the next edge.
REQ-019 Sampled m_out=1: mismatch_count+1, holding at 2^CW-1 once reached.
REQ-020 RUN, enabled cycle with index = WINDOW-1: sample as usual, then -> DONE on the same edge.
REQ-021 Latency: fail/mismatch_count/done visible one cycle after the sampled cycle.
REQ-022 DONE: outputs hold; start=1 -> RUN with clear per REQ-015; otherwise stay.
REQ-023 start during RUN ignored.
REQ-024 m_out ignored in IDLE and DONE.

Reset
REQ-025 reset=1 -> IDLE; busy, done, fail, pass = 0; first_fail_cycle, mismatch_count, cycle index = 0.
REQ-026 reset dominates start and enable in the same cycle, including mid-RUN; no partial result retained.

Configuration
REQ-027 Macro MITER_CHK_STOP_ON_FAIL_EN defined: first sampled mismatch moves RUN -> DONE on the same edge; mismatch_count = 1.
REQ-028 Macro undefined: run always lasts WINDOW enabled cycles regardless of mismatches.

Structure
REQ-029 Package miter_chk_pkg holds the state enum (IDLE, RUN, DONE) and the default CW/WINDOW constants.
REQ-030 One sub-module sat_counter (width CW, clear, increment, saturate) SHALL implement mismatch_count.

Verification
REQ-031 WINDOW=32, start, enable=1, m_out=0 throughout -> done and pass high 32 cycles after RUN entry; mismatch_count=0.
REQ-032 m_out=1 on enabled cycles 5 and 9 -> fail at cycle 6, first_fail_cycle=5, mismatch_count=2, pass=0 in DONE.
REQ-033 enable low 3 cycles mid-run with m_out=1 during them -> no count change; DONE delayed exactly 3 cycles.
REQ-034 reset pulse at enabled cycle 12 with fail set -> IDLE, all outputs 0; subsequent start runs clean.
REQ-035 With MITER_CHK_STOP_ON_FAIL_EN, m_out=1 at index 3 -> done=1, fail=1, first_fail_cycle=3 one cycle later.
REQ-036 CW=2, m_out=1 on every enabled cycle -> mismatch_count saturates at 3; start and reset in the same cycle -> IDLE.
